// File: rtl/march_slot_scheduler.sv
// march_slot_scheduler: sequences sphere-tracing steps for NUM_SLOTS rays
// through one shared, pipelined SDF datapath. Each slot cycles
// FREE -> READY -> IN_FLIGHT -> (READY | DONE) -> FREE.
// Step issue and retirement each scan the slots round-robin.
// Optional: define MARCH_PERF_EN to add the perf_* counter outputs.
module march_slot_scheduler #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned SLOT_W    = 2,
    parameter int unsigned STEP_W    = 8,
    parameter int unsigned MAX_STEPS = 64,
    parameter logic [26:0] MIN_DIST  = 27'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [9:0]        req_x,
    input  logic [9:0]        req_y,
    output logic              iss_valid,
    output logic [SLOT_W-1:0] iss_slot,
    output logic [9:0]        iss_x,
    output logic [9:0]        iss_y,
    output logic [26:0]       iss_depth,
    input  logic              res_valid,
    input  logic [SLOT_W-1:0] res_slot,
    input  logic [26:0]       res_depth,
    input  logic              res_hit,
    input  logic              res_far,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [9:0]        out_x,
    output logic [9:0]        out_y,
    output logic [1:0]        out_status,
    output logic [STEP_W-1:0] out_steps,
    output logic              proto_err
`ifdef MARCH_PERF_EN
    ,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses,
    output logic [31:0]       perf_timeouts,
    output logic [31:0]       perf_idle
`endif
);

    typedef enum logic [1:0] {SLOT_FREE, SLOT_READY, SLOT_INFL, SLOT_DONE} slot_e;
    typedef enum logic [1:0] {ST_HIT = 2'd0, ST_MISS = 2'd1, ST_TIMEOUT = 2'd2} status_e;

    slot_e             state_q  [NUM_SLOTS];
    slot_e             state_d  [NUM_SLOTS];
    logic [9:0]        x_q      [NUM_SLOTS];
    logic [9:0]        x_d      [NUM_SLOTS];
    logic [9:0]        y_q      [NUM_SLOTS];
    logic [9:0]        y_d      [NUM_SLOTS];
    logic [26:0]       depth_q  [NUM_SLOTS];
    logic [26:0]       depth_d  [NUM_SLOTS];
    logic [STEP_W-1:0] steps_q  [NUM_SLOTS];
    logic [STEP_W-1:0] steps_d  [NUM_SLOTS];
    status_e           status_q [NUM_SLOTS];
    status_e           status_d [NUM_SLOTS];

    logic [SLOT_W-1:0] iss_ptr_q, iss_ptr_d, ret_ptr_q, ret_ptr_d;
    logic              iss_valid_q, iss_valid_d;
    logic [SLOT_W-1:0] iss_slot_q, iss_slot_d;
    logic [9:0]        iss_x_q, iss_x_d, iss_y_q, iss_y_d;
    logic [26:0]       iss_depth_q, iss_depth_d;
    logic              out_valid_q, out_valid_d;
    logic [SLOT_W-1:0] out_slot_q, out_slot_d;
    logic [9:0]        out_x_q, out_x_d, out_y_q, out_y_d;
    logic [1:0]        out_status_q, out_status_d;
    logic [STEP_W-1:0] out_steps_q, out_steps_d;
    logic              proto_err_q, proto_err_d;

    logic              free_found, rdy_found, done_found, out_fire;
    logic [SLOT_W-1:0] free_idx, rdy_idx, done_idx;
    logic [STEP_W-1:0] steps_n;

    // Slot selection: lowest FREE slot, and round-robin READY / DONE scans
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        done_found = 1'b0;
        done_idx   = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!free_found && state_q[i] == SLOT_FREE) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
            if (!rdy_found && state_q[iss_ptr_q + SLOT_W'(i)] == SLOT_READY) begin
                rdy_found = 1'b1;
                rdy_idx   = iss_ptr_q + SLOT_W'(i);
            end
            if (!done_found && state_q[ret_ptr_q + SLOT_W'(i)] == SLOT_DONE) begin
                done_found = 1'b1;
                done_idx   = ret_ptr_q + SLOT_W'(i);
            end
        end
    end

    assign req_ready = free_found;
    assign out_fire  = out_valid_q && out_ready;

    // Next-state: accept, issue, result and retire each touch a slot in a distinct state
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        depth_d      = depth_q;
        steps_d      = steps_q;
        status_d     = status_q;
        iss_ptr_d    = iss_ptr_q;
        ret_ptr_d    = ret_ptr_q;
        iss_valid_d  = 1'b0;
        iss_slot_d   = iss_slot_q;
        iss_x_d      = iss_x_q;
        iss_y_d      = iss_y_q;
        iss_depth_d  = iss_depth_q;
        out_valid_d  = out_valid_q;
        out_slot_d   = out_slot_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_status_d = out_status_q;
        out_steps_d  = out_steps_q;
        proto_err_d  = proto_err_q;
        steps_n      = '0;

        if (req_valid && free_found) begin
            state_d[free_idx] = SLOT_READY;
            x_d[free_idx]     = req_x;
            y_d[free_idx]     = req_y;
            depth_d[free_idx] = MIN_DIST;
            steps_d[free_idx] = '0;
        end

        if (rdy_found) begin
            state_d[rdy_idx] = SLOT_INFL;
            iss_valid_d      = 1'b1;
            iss_slot_d       = rdy_idx;
            iss_x_d          = x_q[rdy_idx];
            iss_y_d          = y_q[rdy_idx];
            iss_depth_d      = depth_q[rdy_idx];
            iss_ptr_d        = rdy_idx + SLOT_W'(1);
        end

        if (res_valid) begin
            if (state_q[res_slot] == SLOT_INFL) begin
                steps_n           = steps_q[res_slot] + STEP_W'(1);
                steps_d[res_slot] = steps_n;
                if (res_hit) begin
                    state_d[res_slot]  = SLOT_DONE;
                    status_d[res_slot] = ST_HIT;
                end else if (res_far) begin
                    state_d[res_slot]  = SLOT_DONE;
                    status_d[res_slot] = ST_MISS;
                end else if (steps_n == STEP_W'(MAX_STEPS)) begin
                    state_d[res_slot]  = SLOT_DONE;
                    status_d[res_slot] = ST_TIMEOUT;
                end else begin
                    state_d[res_slot]  = SLOT_READY;
                    depth_d[res_slot]  = res_depth;
                end
            end else begin
                proto_err_d = 1'b1;
            end
        end

        // The presented slot is latched so a newly DONE slot earlier in the
        // rotation cannot displace it while out_valid waits for out_ready.
        if (out_fire) begin
            state_d[out_slot_q] = SLOT_FREE;
            ret_ptr_d           = out_slot_q + SLOT_W'(1);
            out_valid_d         = 1'b0;
        end else if (!out_valid_q && done_found) begin
            out_valid_d  = 1'b1;
            out_slot_d   = done_idx;
            out_x_d      = x_q[done_idx];
            out_y_d      = y_q[done_idx];
            out_status_d = status_q[done_idx];
            out_steps_d  = steps_q[done_idx];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                state_q[i]  <= SLOT_FREE;
                x_q[i]      <= '0;
                y_q[i]      <= '0;
                depth_q[i]  <= '0;
                steps_q[i]  <= '0;
                status_q[i] <= ST_HIT;
            end
            iss_ptr_q    <= '0;
            ret_ptr_q    <= '0;
            iss_valid_q  <= 1'b0;
            iss_slot_q   <= '0;
            iss_x_q      <= '0;
            iss_y_q      <= '0;
            iss_depth_q  <= '0;
            out_valid_q  <= 1'b0;
            out_slot_q   <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_status_q <= '0;
            out_steps_q  <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            depth_q      <= depth_d;
            steps_q      <= steps_d;
            status_q     <= status_d;
            iss_ptr_q    <= iss_ptr_d;
            ret_ptr_q    <= ret_ptr_d;
            iss_valid_q  <= iss_valid_d;
            iss_slot_q   <= iss_slot_d;
            iss_x_q      <= iss_x_d;
            iss_y_q      <= iss_y_d;
            iss_depth_q  <= iss_depth_d;
            out_valid_q  <= out_valid_d;
            out_slot_q   <= out_slot_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_status_q <= out_status_d;
            out_steps_q  <= out_steps_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign iss_valid  = iss_valid_q;
    assign iss_slot   = iss_slot_q;
    assign iss_x      = iss_x_q;
    assign iss_y      = iss_y_q;
    assign iss_depth  = iss_depth_q;
    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_status = out_status_q;
    assign out_steps  = out_steps_q;
    assign proto_err  = proto_err_q;

`ifdef MARCH_PERF_EN
    logic [31:0] perf_hits_q, perf_hits_d, perf_misses_q, perf_misses_d;
    logic [31:0] perf_timeouts_q, perf_timeouts_d, perf_idle_q, perf_idle_d;
    logic        any_busy;

    // Perf counters: retire outcomes per status, and busy cycles without an issue
    always_comb begin
        perf_hits_d     = perf_hits_q;
        perf_misses_d   = perf_misses_q;
        perf_timeouts_d = perf_timeouts_q;
        perf_idle_d     = perf_idle_q;
        any_busy        = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (state_q[i] != SLOT_FREE) any_busy = 1'b1;
        end
        if (out_fire) begin
            case (out_status_q)
                2'd0:    perf_hits_d     = perf_hits_q + 32'd1;
                2'd1:    perf_misses_d   = perf_misses_q + 32'd1;
                default: perf_timeouts_d = perf_timeouts_q + 32'd1;
            endcase
        end
        if (any_busy && !iss_valid_q) perf_idle_d = perf_idle_q + 32'd1;
    end

    // Perf counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hits_q     <= '0;
            perf_misses_q   <= '0;
            perf_timeouts_q <= '0;
            perf_idle_q     <= '0;
        end else begin
            perf_hits_q     <= perf_hits_d;
            perf_misses_q   <= perf_misses_d;
            perf_timeouts_q <= perf_timeouts_d;
            perf_idle_q     <= perf_idle_d;
        end
    end

    assign perf_hits     = perf_hits_q;
    assign perf_misses   = perf_misses_q;
    assign perf_timeouts = perf_timeouts_q;
    assign perf_idle     = perf_idle_q;
`endif

endmodule

// File: tb/tb_march_slot_scheduler.sv
// tb_march_slot_scheduler: scoreboard bench for march_slot_scheduler.
// Each ray gets a plan (step at which the datapath reports hit / far); the
// expected retirement is derived from that plan when the request is accepted
// and checked by an independent monitor when the ray retires.
module tb_march_slot_scheduler;

    localparam int MAX_STEPS = 64;
    localparam int LAT       = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_x, req_y;
    logic        iss_valid;
    logic [1:0]  iss_slot;
    logic [9:0]  iss_x, iss_y;
    logic [26:0] iss_depth;
    logic        res_valid;
    logic [1:0]  res_slot;
    logic [26:0] res_depth;
    logic        res_hit, res_far;
    logic        out_valid, out_ready;
    logic [9:0]  out_x, out_y;
    logic [1:0]  out_status;
    logic [7:0]  out_steps;
    logic        proto_err;

    // result source select: datapath model or direct bench drive
    logic        dp_en;
    logic        dp_valid, dp_hit, dp_far;
    logic [1:0]  dp_slot;
    logic [26:0] dp_depth;
    logic        tb_res_valid;
    logic [1:0]  tb_res_slot;
    assign res_valid = dp_en ? dp_valid : tb_res_valid;
    assign res_slot  = dp_en ? dp_slot  : tb_res_slot;
    assign res_depth = dp_en ? dp_depth : 27'h0;
    assign res_hit   = dp_en ? dp_hit   : 1'b0;
    assign res_far   = dp_en ? dp_far   : 1'b0;

    logic rdy_mode, rdy_fixed, rdy_rand;
    assign out_ready = rdy_mode ? rdy_rand : rdy_fixed;

    march_slot_scheduler #(
        .NUM_SLOTS (4),
        .SLOT_W    (2),
        .STEP_W    (8),
        .MAX_STEPS (MAX_STEPS),
        .MIN_DIST  (27'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .iss_valid  (iss_valid),
        .iss_slot   (iss_slot),
        .iss_x      (iss_x),
        .iss_y      (iss_y),
        .iss_depth  (iss_depth),
        .res_valid  (res_valid),
        .res_slot   (res_slot),
        .res_depth  (res_depth),
        .res_hit    (res_hit),
        .res_far    (res_far),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_status (out_status),
        .out_steps  (out_steps),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // per-pixel plan and progress, keyed by {x,y}
    int          hit_k     [int];
    int          far_k     [int];
    int          nsteps    [int];
    logic [26:0] exp_depth [int];

    typedef struct {int key; int status; int steps;} exp_t;
    exp_t sb[$];
    int   ret_log[$];
    int   iss_log[$];
    bit   log_en = 0;
    int   n_iss = 0;
    int   last_hs_cyc = -100;
    int   last_acc_cyc = 0;

    // Expected outcome: the earliest terminating step wins (hit beats far on a
    // tie); no termination within MAX_STEPS means TIMEOUT after MAX_STEPS steps.
    function automatic void expect_of(input int hk, input int fk, output int st, output int sp);
        int t = 0;
        if (hk > 0) t = hk;
        if (fk > 0 && (t == 0 || fk < t)) t = fk;
        if (t > 0 && t <= MAX_STEPS) begin
            sp = t;
            st = (hk == t) ? 0 : 1;
        end else begin
            sp = MAX_STEPS;
            st = 2;
        end
    endfunction

    // Datapath model: fixed-latency pipe, answers each issue from the pixel's plan
    logic        pv [LAT];
    logic [1:0]  ps [LAT];
    logic [26:0] pd [LAT];
    logic        ph [LAT];
    logic        pf [LAT];
    int          dk, ds;
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < LAT; j++) pv[j] = 1'b0;
            dp_valid = 1'b0;
        end else begin
            for (int j = LAT - 1; j > 0; j--) begin
                pv[j] = pv[j-1]; ps[j] = ps[j-1]; pd[j] = pd[j-1];
                ph[j] = ph[j-1]; pf[j] = pf[j-1];
            end
            pv[0] = 1'b0;
            if (iss_valid) begin
                n_iss++;
                if (log_en) iss_log.push_back(int'(iss_slot));
                dk = int'({iss_x, iss_y});
                if (!nsteps.exists(dk)) begin
                    chk("iss_unknown_pixel", 64'(dk), 64'hFFFFFFFF);
                end else begin
                    chk("iss_depth", 64'(iss_depth), 64'(exp_depth[dk]));
                    nsteps[dk] = nsteps[dk] + 1;
                    ds = nsteps[dk];
                    pv[0] = 1'b1;
                    ps[0] = iss_slot;
                    pd[0] = 27'($urandom);
                    ph[0] = (hit_k[dk] == ds);
                    pf[0] = (far_k[dk] == ds);
                    exp_depth[dk] = pd[0];
                end
            end
            dp_valid = pv[LAT-1];
            dp_slot  = ps[LAT-1];
            dp_depth = pd[LAT-1];
            dp_hit   = ph[LAT-1];
            dp_far   = pf[LAT-1];
        end
    end

    always @(negedge clk) rdy_rand = ($urandom_range(0, 3) != 0);

    // Monitor: hold stability and retirement against the scoreboard
    bit          prev_hold = 0;
    logic [29:0] prev_data;
    int          mk, midx;
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                chk("out_hold_valid", 64'(out_valid), 64'd1);
                chk("out_hold_data", 64'({out_x, out_y, out_status, out_steps}), 64'(prev_data));
            end
            prev_hold = out_valid && !out_ready;
            prev_data = {out_x, out_y, out_status, out_steps};
            if (out_valid && out_ready) begin
                mk = int'({out_x, out_y});
                midx = -1;
                foreach (sb[i]) if (midx < 0 && sb[i].key == mk) midx = i;
                if (midx < 0) begin
                    chk("retire_unexpected_pixel", 64'(mk), 64'hFFFFFFFF);
                end else begin
                    chk("out_status", 64'(out_status), 64'(sb[midx].status));
                    chk("out_steps", 64'(out_steps), 64'(sb[midx].steps));
                    chk("issue_count", 64'(nsteps[mk]), 64'(sb[midx].steps));
                    sb.delete(midx);
                end
                ret_log.push_back(mk);
                last_hs_cyc = cyc;
            end
        end
    end

    // All driver tasks are entered and left at a negedge.
    task automatic send_req(input int x, input int y, input int hk, input int fk);
        int   key = x * 1024 + y;
        exp_t e;
        hit_k[key] = hk; far_k[key] = fk; nsteps[key] = 0; exp_depth[key] = 27'h0;
        req_x = 10'(x); req_y = 10'(y); req_valid = 1'b1;
        for (int t = 0; ; t++) begin
            if (req_ready) begin
                e.key = key;
                expect_of(hk, fk, e.status, e.steps);
                sb.push_back(e);
                last_acc_cyc = cyc;
                @(negedge clk);
                break;
            end
            if (t > 3000) begin
                chk("req_accept_timeout", 64'd0, 64'd1);
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int t = 0;
        while (sb.size() != 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        chk("drain_outstanding", 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_iss_valid", 64'(iss_valid), 64'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    int base, n0, hold_iss, nx;
    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0;
        dp_en = 1'b0; tb_res_valid = 1'b0; tb_res_slot = '0;
        rdy_mode = 1'b0; rdy_fixed = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // reset state
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_iss_valid", 64'(iss_valid), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_proto_err", 64'(proto_err), 64'd0);
        chk("reset_out_data", 64'({out_x, out_y, out_status, out_steps}), 64'd0);
        chk("reset_iss_data", 64'({iss_slot, iss_x, iss_y, iss_depth}), 64'd0);

        // result for a FREE slot
        tb_res_valid = 1'b1; tb_res_slot = 2'd2;
        @(negedge clk);
        tb_res_valid = 1'b0;
        chk("proto_err_set", 64'(proto_err), 64'd1);
        chk("proto_slots_free", 64'(req_ready), 64'd1);
        chk("proto_no_issue", 64'(iss_valid), 64'd0);
        chk("proto_no_retire", 64'(out_valid), 64'd0);
        repeat (5) @(negedge clk);
        chk("proto_err_sticky", 64'(proto_err), 64'd1);
        pulse_reset();
        chk("proto_err_cleared", 64'(proto_err), 64'd0);
        dp_en = 1'b1;

        // single ray, hit on third step; timeout ray; hit+far on step 64
        send_req(5, 7, 3, 0);
        drain(200);
        send_req(6, 1, 0, 0);
        drain(1000);
        send_req(7, 1, 64, 64);
        drain(1000);
        send_req(8, 2, 0, 12);
        drain(400);

        // five back-to-back requests from pointer 0
        pulse_reset();
        iss_log.delete();
        log_en = 1;
        for (int i = 0; i < 4; i++) send_req(10 + i, 3, 10, 0);
        chk("req_ready_full", 64'(req_ready), 64'd0);
        send_req(14, 3, 10, 0);
        chk("fifth_accept_after_retire", 64'(last_acc_cyc - last_hs_cyc), 64'd1);
        drain(1000);
        log_en = 0;
        chk("iss_log_len_ok", 64'(iss_log.size() >= 5), 64'd1);
        if (iss_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("iss_rotation", 64'(iss_log[i]), 64'(i % 4));
        end

        // consumer stalls while two rays finish and two keep stepping
        rdy_fixed = 1'b0;
        base = ret_log.size();
        send_req(20, 4, 2, 0);
        send_req(21, 4, 2, 0);
        send_req(22, 4, 40, 0);
        send_req(23, 4, 40, 0);
        n0 = n_iss;
        repeat (10) @(negedge clk);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        repeat (10) @(negedge clk);
        hold_iss = n_iss - n0;
        chk("stall_issues_continue", 64'(hold_iss >= 10), 64'd1);
        chk("stall_nothing_retired", 64'(ret_log.size() - base), 64'd0);
        rdy_fixed = 1'b1;
        drain(2000);
        chk("stall_retired_count", 64'(ret_log.size() - base), 64'd4);
        if (ret_log.size() - base >= 2) begin
            chk("stall_order_first", 64'(ret_log[base]), 64'(20 * 1024 + 4));
            chk("stall_order_second", 64'(ret_log[base + 1]), 64'(21 * 1024 + 4));
        end

        // randomized traffic with a random consumer
        rdy_mode = 1'b1;
        for (int r = 0; r < 40; r++) begin
            int hk, fk;
            hk = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 80));
            fk = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 80));
            send_req(100 + r, int'($urandom_range(0, 1023)), hk, fk);
            nx = int'($urandom_range(0, 3));
            repeat (nx) @(negedge clk);
        end
        drain(20000);
        rdy_mode = 1'b0;
        chk("no_proto_err_in_traffic", 64'(proto_err), 64'd0);

        // reset with rays in flight discards them
        send_req(300, 1, 0, 0);
        send_req(301, 1, 0, 0);
        send_req(302, 1, 0, 0);
        repeat (8) @(negedge clk);
        pulse_reset();
        chk("post_rst_proto_err", 64'(proto_err), 64'd0);
        repeat (10) @(negedge clk);
        chk("post_rst_idle_issue", 64'(iss_valid), 64'd0);
        chk("post_rst_idle_out", 64'(out_valid), 64'd0);

        // the scheduler still works after the mid-flight reset
        send_req(400, 9, 5, 0);
        drain(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/march_slot_scheduler.md
Name: march_slot_scheduler

Overview:
- Controller that sequences the sphere-tracing loop for multiple rays through one shared, pipelined SDF step datapath.
- Accepts pixel requests and holds each ray in one of NUM_SLOTS ray slots.
- Issues at most one step per cycle, round-robin across ready slots; applies the termination results the datapath returns; retires finished rays with status and step count.
- Sits between the pixel scan source and the colour stage; the datapath (frag direction, depth*dir, SDF, depth add, compares) is external.

Parameters:
- NUM_SLOTS, 4, number of concurrent rays (power of two, 2..8).
- SLOT_W, 2, log2(NUM_SLOTS).
- STEP_W, 8, width of per-ray step counter.
- MAX_STEPS, 64, step limit (1..2^STEP_W-1).
- MIN_DIST, 27'h0, initial depth (27-bit project float).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  1  new pixel request
- req_ready  out  1  a FREE slot exists
- req_x  in  10  pixel x
- req_y  in  10  pixel y
- iss_valid  out  1  step issued to datapath this cycle
- iss_slot  out  SLOT_W  issuing slot id
- iss_x  out  10  slot pixel x
- iss_y  out  10  slot pixel y
- iss_depth  out  27  slot current depth (float)
- res_valid  in  1  datapath result
- res_slot  in  SLOT_W  result slot id
- res_depth  in  27  depth+dist (float)
- res_hit  in  1  dist < EPSILON
- res_far  in  1  new depth >= MAX_DIST
- out_valid  out  1  retired ray available
- out_ready  in  1  consumer accepts
- out_x  out  10  retired pixel x
- out_y  out  10  retired pixel y
- out_status  out  2  0=HIT, 1=MISS, 2=TIMEOUT
- out_steps  out  STEP_W  SDF evaluations performed
- proto_err  out  1  sticky protocol error

Behaviour:
- Reset (rst_n low, async): all slots FREE; issue and retire round-robin pointers = 0; iss_valid=0, out_valid=0, proto_err=0; all data outputs 0.
- Per-slot state: FREE -> READY (accept) -> IN_FLIGHT (issue) -> READY (result, continue) or DONE (result, terminate) -> FREE (retire handshake).
- Accept: on req_valid&&req_ready, the lowest-index FREE slot captures x/y, depth=MIN_DIST, steps=0, and becomes READY next cycle. req_ready is combinational from slot states: high iff any slot is FREE.
- Issue: when any slot is READY, choose the first READY slot at or after the issue pointer (wrapping). The chosen slot drives iss_* and goes IN_FLIGHT; the pointer moves to chosen+1 mod NUM_SLOTS. iss_* is registered (1-cycle latency from the state decision). There is no datapath backpressure: the datapath accepts one issue per cycle.
- Result, on res_valid for an IN_FLIGHT slot: steps_n = steps+1; priority hit > far > timeout.
  - res_hit: DONE, status HIT.
  - else res_far: DONE, status MISS.
  - else steps_n==MAX_STEPS: DONE, status TIMEOUT.
  - else depth=res_depth, READY.
  - steps = steps_n in every case.
- Result for a slot not IN_FLIGHT: ignored, proto_err set (sticky until reset).
- Retire: out_* is presented from the first DONE slot at or after the retire pointer. out_valid is held with stable data until out_ready. On the handshake the slot becomes FREE next cycle and the pointer moves to slot+1. Output order need not match request order; x/y identify the pixel.
- State changes are registered and a slot makes at most one transition per cycle:
  - A result cannot make its slot issue in the same cycle.
  - A slot freed by retire cannot be allocated in the same cycle.
  - Accept, issue, result and retire on different slots in one cycle are all honoured.
- Reset mid-operation discards all rays. The datapath is reset by the same rst_n.

Optional Feature:
- Macro MARCH_PERF_EN.
- Defined: adds outputs perf_hits, perf_misses, perf_timeouts (32 bits each, incremented on the retire handshake per status, wrapping) and perf_idle (32 bits, counts cycles with ≥1 non-FREE slot and iss_valid=0). All reset to 0.
- Undefined: these ports and counters do not exist.

Test Plan:
- Reset, then one request (x=5, y=7) with a model datapath of latency 3 returning res_hit on the 3rd result -> out_valid with x=5, y=7, status 0, steps 3; iss_depth on the first issue = 27'h0.
- One request whose results are never hit or far, MAX_STEPS=64 -> exactly 64 issues, then TIMEOUT with steps=64.
- Five back-to-back requests, NUM_SLOTS=4 -> req_ready low after the 4th accept; the 5th is accepted the cycle after the first retire; issues rotate slots 0,1,2,3,0.
- out_ready held low for 10 cycles with 2 rays DONE -> out_* stable; other slots keep issuing; both retire in round-robin order once out_ready=1.
- res_valid with res_slot=2 while slot 2 is FREE -> proto_err=1 and stays set; slot states unchanged.
- res_hit=1 and res_far=1 together on the 64th step -> status HIT, steps 64. rst_n pulsed low with 3 rays in flight -> req_ready=1, out_valid=0, iss_valid=0 immediately.
